fpu_issue_queue: RTL and testbench

FPU_ISSUE_QUEUE -- requirements
Module: fpu_issue_queue

---
 rtl/fpu_issue_queue_if.sv | 30 +++
 rtl/fpu_issue_queue.sv | 123 ++++++++++++
 tb/tb_fpu_issue_queue.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fpu_issue_queue_if.sv
// Handshake bundle between a request producer, the FPU issue queue and the FPU.
// The queue connects through the slave modport; producer/FPU side through master.
interface fpu_issue_queue_if #(
  parameter int bitness = 32
);
  logic               push_valid;
  logic               push_ready;
  logic [bitness-1:0] push_a;
  logic [bitness-1:0] push_b;
  logic [3:0]         push_op;
  logic               fpu_input_rdy;
  logic               fpu_input_ack;
  logic [bitness-1:0] fpu_data_a;
  logic [bitness-1:0] fpu_data_b;
  logic [3:0]         fpu_operation;
  logic               fpu_output_rdy;
  logic               fpu_output_ack;

  modport master (
    output push_valid, push_a, push_b, push_op,
    output fpu_input_ack, fpu_output_rdy, fpu_output_ack,
    input  push_ready, fpu_input_rdy, fpu_data_a, fpu_data_b, fpu_operation
  );

  modport slave (
    input  push_valid, push_a, push_b, push_op,
    input  fpu_input_ack, fpu_output_rdy, fpu_output_ack,
    output push_ready, fpu_input_rdy, fpu_data_a, fpu_data_b, fpu_operation
  );
endinterface

// File: rtl/fpu_issue_queue.sv
// Circular FIFO of {a, b, op} requests issued one at a time to an FPU.
// Define FPU_ISSUE_OPCHECK_EN to drop op codes above 3 and flag them on op_error.
module fpu_issue_queue #(
  parameter int bitness = 32,
  parameter int depth   = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  fpu_issue_queue_if.slave       q,
  output logic [$clog2(depth):0] count,
  output logic                   busy
`ifdef FPU_ISSUE_OPCHECK_EN
  ,
  output logic                   op_error
`endif
);

  localparam int PW = $clog2(depth);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(depth);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  typedef enum logic [1:0] {IDLE, PRESENT, BUSY} state_t;

  typedef struct packed {
    logic [bitness-1:0] a;
    logic [bitness-1:0] b;
    logic [3:0]         op;
  } entry_t;

  entry_t        mem_q [depth];
  entry_t        head;
  state_t        state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          input_rdy_q, input_rdy_d;
  logic          busy_q, busy_d;
  logic          push_fire;
  logic          store;
  logic          pop;
`ifdef FPU_ISSUE_OPCHECK_EN
  logic          op_error_q, op_error_d;
  logic          op_bad;
`endif

  always_comb begin
    push_fire = q.push_valid && (count_q < DEPTH_C);
    store     = push_fire;
`ifdef FPU_ISSUE_OPCHECK_EN
    op_bad     = q.push_op > 4'd3;
    store      = push_fire && !op_bad;
    op_error_d = op_error_q || (push_fire && op_bad);
`endif
    // Pop only on the PRESENT->BUSY transition, so a held ack pops once.
    pop = (state_q == PRESENT) && q.fpu_input_ack;

    wr_ptr_d = store ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop   ? rd_ptr_q + PTR_ONE : rd_ptr_q;

    unique case ({store, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    state_d = state_q;
    unique case (state_q)
      IDLE:    if (count_q != '0) state_d = PRESENT;
      PRESENT: if (q.fpu_input_ack) state_d = BUSY;
      BUSY:    if (q.fpu_output_rdy && q.fpu_output_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    input_rdy_d = (state_d == PRESENT);
    busy_d      = (state_d == BUSY);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      input_rdy_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef FPU_ISSUE_OPCHECK_EN
      op_error_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      input_rdy_q <= input_rdy_d;
      busy_q      <= busy_d;
`ifdef FPU_ISSUE_OPCHECK_EN
      op_error_q  <= op_error_d;
`endif
    end
  end

  // Storage is left uncleared by reset; the pointers and count define validity.
  always_ff @(posedge clock) begin
    if (store) mem_q[wr_ptr_q] <= '{a: q.push_a, b: q.push_b, op: q.push_op};
  end

  always_comb begin
    head            = mem_q[rd_ptr_q];
    q.push_ready    = count_q < DEPTH_C;
    q.fpu_input_rdy = input_rdy_q;
    q.fpu_data_a    = (count_q != '0) ? head.a  : '0;
    q.fpu_data_b    = (count_q != '0) ? head.b  : '0;
    q.fpu_operation = (count_q != '0) ? head.op : '0;
    count           = count_q;
    busy            = busy_q;
`ifdef FPU_ISSUE_OPCHECK_EN
    op_error        = op_error_q;
`endif
  end

endmodule

// File: tb/tb_fpu_issue_queue.sv
// Scoreboard bench for fpu_issue_queue: directed scenarios then random traffic,
// with a negedge monitor comparing the DUT against a queue-based model.
module tb_fpu_issue_queue;

  localparam int DEPTH = 4;

  logic       clock;
  logic       reset;
  logic [2:0] count;
  logic       busy;
`ifdef FPU_ISSUE_OPCHECK_EN
  logic       op_error;
`endif

  fpu_issue_queue_if #(.bitness(32)) bus ();

  fpu_issue_queue #(.bitness(32), .depth(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .q     (bus),
    .count (count),
    .busy  (busy)
`ifdef FPU_ISSUE_OPCHECK_EN
    ,
    .op_error (op_error)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
  } ent_t;

  ent_t exp_q[$];
  bit   in_flight;
  int   stall;
  bit   err_m;
  int   total;
  int   bad;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Monitor: model reflects state after the previous edge; then it applies the
  // handshakes the coming edge will see.
  initial begin
    in_flight = 0; stall = 0; err_m = 0; total = 0; bad = 0;
    forever begin
      bit old_if;
      bit drop;
      ent_t e;
      @(negedge clock);
      if (reset) begin
        exp_q.delete();
        in_flight = 0;
        stall = 0;
        err_m = 0;
        continue;
      end
      check("count", count, exp_q.size());
      check("busy", busy, in_flight);
      check("push_ready", bus.push_ready, exp_q.size() < DEPTH);
      check("rdy_while_busy", bus.fpu_input_rdy && in_flight, 0);
      check("rdy_when_empty", bus.fpu_input_rdy && exp_q.size() == 0, 0);
`ifdef FPU_ISSUE_OPCHECK_EN
      check("op_error", op_error, err_m);
`endif
      if (exp_q.size() == 0) begin
        check("data_a_empty", bus.fpu_data_a, 0);
        check("data_b_empty", bus.fpu_data_b, 0);
      end
      if (bus.fpu_input_rdy && exp_q.size() > 0) begin
        e = exp_q[0];
        check("head_a", bus.fpu_data_a, e.a);
        check("head_b", bus.fpu_data_b, e.b);
        check("head_op", bus.fpu_operation, e.op);
      end
      if (!in_flight && exp_q.size() > 0 && !bus.fpu_input_rdy) stall++;
      else stall = 0;
      check("issue_stall", stall > 1, 0);

      old_if = in_flight;
      if (bus.push_valid && bus.push_ready) begin
        drop = 0;
`ifdef FPU_ISSUE_OPCHECK_EN
        drop = bus.push_op > 4'd3;
        if (drop) err_m = 1;
`endif
        if (!drop) exp_q.push_back('{a: bus.push_a, b: bus.push_b, op: bus.push_op});
      end
      if (bus.fpu_input_rdy && bus.fpu_input_ack && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        in_flight = 1;
      end
      if (old_if && bus.fpu_output_rdy && bus.fpu_output_ack) in_flight = 0;
    end
  end

  initial begin
    reset = 1'b1;
    bus.push_valid = 0; bus.push_a = '0; bus.push_b = '0; bus.push_op = '0;
    bus.fpu_input_ack = 0; bus.fpu_output_rdy = 0; bus.fpu_output_ack = 0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_count", count, 0);
    check("rst_push_ready", bus.push_ready, 1);
    check("rst_rdy", bus.fpu_input_rdy, 0);
    check("rst_busy", busy, 0);
    check("rst_data_a", bus.fpu_data_a, 0);
    #1 reset = 1'b0;

    // Single request: issue latency of two cycles, then ack and complete
    bus.push_valid = 1; bus.push_a = 32'h3F80_0000; bus.push_b = 32'h4000_0000; bus.push_op = 4'b0000;
    step();
    check("lat_count", count, 1);
    check("lat_rdy_n1", bus.fpu_input_rdy, 0);
    bus.push_valid = 0;
    step();
    check("lat_rdy_n2", bus.fpu_input_rdy, 1);
    check("lat_a", bus.fpu_data_a, 32'h3F80_0000);
    check("lat_b", bus.fpu_data_b, 32'h4000_0000);
    check("lat_op", bus.fpu_operation, 0);
    bus.fpu_input_ack = 1;
    step();
    check("ack_count", count, 0);
    check("ack_busy", busy, 1);
    check("ack_rdy", bus.fpu_input_rdy, 0);
    bus.fpu_input_ack = 0; bus.fpu_output_rdy = 1; bus.fpu_output_ack = 1;
    step();
    check("done_busy", busy, 0);
    bus.fpu_output_rdy = 0; bus.fpu_output_ack = 0;

    // Fill to capacity without acks
    for (int i = 0; i < DEPTH; i++) begin
      bus.push_valid = 1; bus.push_a = 32'h100 + i; bus.push_b = 32'h200 + i; bus.push_op = 4'(i);
      step();
    end
    check("full_count", count, 4);
    check("full_ready", bus.push_ready, 0);
    bus.push_a = 32'hDEAD_0005; bus.push_b = 32'hBEEF_0005; bus.push_op = 4'd2;
    step();
    check("full_refuse_count", count, 4);
    check("full_head_a", bus.fpu_data_a, 32'h100);
    check("full_rdy", bus.fpu_input_rdy, 1);

    // Full with simultaneous push and ack: push refused, then accepted
    bus.fpu_input_ack = 1;
    check("full_ack_ready", bus.push_ready, 0);
    step();
    check("full_ack_count", count, 3);
    check("full_ack_busy", busy, 1);
    bus.fpu_input_ack = 0;
    check("after_ack_ready", bus.push_ready, 1);
    step();
    check("refill_count", count, 4);
    bus.push_valid = 0;

    // Finish in-flight op, then hold ack for five cycles: one pop only
    bus.fpu_output_rdy = 1; bus.fpu_output_ack = 1;
    step();
    bus.fpu_output_rdy = 0; bus.fpu_output_ack = 0;
    bus.fpu_input_ack = 1;
    repeat (5) step();
    check("hold_ack_count", count, 3);
    check("hold_ack_busy", busy, 1);
    check("hold_ack_rdy", bus.fpu_input_rdy, 0);
    bus.fpu_input_ack = 0; bus.fpu_output_rdy = 1; bus.fpu_output_ack = 1;
    step();
    bus.fpu_output_rdy = 0; bus.fpu_output_ack = 0;
    step();
    check("reissue_rdy", bus.fpu_input_rdy, 1);

    // Asynchronous reset in BUSY with two entries queued
    bus.fpu_input_ack = 1;
    step();
    bus.fpu_input_ack = 0;
    check("pre_rst_count", count, 2);
    check("pre_rst_busy", busy, 1);
    #2 reset = 1'b1;
    #1;
    check("arst_count", count, 0);
    check("arst_busy", busy, 0);
    check("arst_rdy", bus.fpu_input_rdy, 0);
    check("arst_ready", bus.push_ready, 1);
    step();
    #1 reset = 1'b0;
    bus.push_valid = 1; bus.push_a = 32'h1234_5678; bus.push_b = 32'h9ABC_DEF0; bus.push_op = 4'b0101;
    step();
    bus.push_valid = 0;
`ifdef FPU_ISSUE_OPCHECK_EN
    check("badop_count", count, 0);
    check("badop_err", op_error, 1);
`else
    check("op5_count", count, 1);
`endif
    step();
`ifndef FPU_ISSUE_OPCHECK_EN
    check("op5_issued", bus.fpu_operation, 4'b0101);
`endif
    bus.fpu_input_ack = 1; bus.fpu_output_rdy = 1; bus.fpu_output_ack = 1;
    repeat (6) step();
    check("drain1_count", count, 0);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      bus.push_valid     = ($urandom % 3) != 0;
      bus.push_a         = $urandom;
      bus.push_b         = $urandom;
      bus.push_op        = 4'($urandom % 16);
      bus.fpu_input_ack  = ($urandom % 2) != 0;
      bus.fpu_output_rdy = ($urandom % 3) != 0;
      bus.fpu_output_ack = ($urandom % 2) != 0;
      step();
    end
    bus.push_valid = 0;
    bus.fpu_input_ack = 1; bus.fpu_output_rdy = 1; bus.fpu_output_ack = 1;
    repeat (4 * DEPTH + 8) step();
    check("final_count", count, 0);
    check("final_busy", busy, 0);

    @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
